mult_arb: RTL and testbench

//  Arbiter/sequencer for the single shared signed multiplier (24x16 -> 40 bit).

---
 rtl/mult_arb_pkg.sv | 22 ++
 rtl/mult_arb_pick.sv | 48 ++++
 rtl/mult_arb.sv | 133 +++++++++++++
 tb/tb_mult_arb.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and default widths for the multiplier arbiter.
// Build option: MULT_ARB_RR_EN selects round-robin instead of fixed priority.
package mult_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int A_W_DEF     = 24;
    localparam int B_W_DEF     = 16;
    localparam int P_W_DEF     = A_W_DEF + B_W_DEF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arb_pick.sv
// Combinational winner selection for mult_arb.
// MULT_ARB_RR_EN: round-robin from last grant; otherwise lowest index wins.
module mult_arb_pick
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifdef MULT_ARB_RR_EN
    input  logic [IW-1:0]      last_i,
`endif
    output logic               valid_o,
    output logic [IW-1:0]      idx_o
);

`ifdef MULT_ARB_RR_EN
    // Walk backwards so the nearest requester after last_i is written last.
    always_comb begin
        logic [IW:0] pos;
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = {1'b0, last_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_REQ)) begin
                pos = pos - (IW+1)'(NUM_REQ);
            end
            if (req_i[pos[IW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = pos[IW-1:0];
            end
        end
    end
`else
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mult_arb.sv
// Arbiter/sequencer sharing one signed multiplier between several requesters.
// Build option: MULT_ARB_RR_EN enables round-robin arbitration.
module mult_arb
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int P_W     = P_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*A_W-1:0] req_a_i,
    input  logic [NUM_REQ*B_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [P_W-1:0]         prod_o,
    output logic                   busy_o,
    output logic                   mult_start_o,
    output logic [A_W-1:0]         mult_a_o,
    output logic [B_W-1:0]         mult_b_o,
    input  logic                   mult_ready_i,
    input  logic [P_W-1:0]         mult_prod_i
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [A_W-1:0] a_q, a_d;
    logic [B_W-1:0] b_q, b_d;
    logic [P_W-1:0] prod_q, prod_d;
    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic [A_W-1:0] sel_a;
    logic [B_W-1:0] sel_b;
`ifdef MULT_ARB_RR_EN
    logic [IW-1:0]  last_q, last_d;
`endif

    mult_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_i),
`ifdef MULT_ARB_RR_EN
        .last_i  (last_q),
`endif
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_a = req_a_i[i*A_W +: A_W];
                sel_b = req_b_i[i*B_W +: B_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
`ifdef MULT_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    state_d = START;
`ifdef MULT_ARB_RR_EN
                    last_d  = pick_idx;
`endif
                end
            end
            START:  state_d = SETTLE;
            // Ready may still be high from the previous product here.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (mult_ready_i) begin
                    prod_d  = mult_prod_i;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
`ifdef MULT_ARB_RR_EN
            last_q  <= IW'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
`ifdef MULT_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_q == DONE) begin
            ack_o[grant_q] = 1'b1;
        end
    end

    assign prod_o       = prod_q;
    assign busy_o       = (state_q != IDLE);
    assign mult_start_o = (state_q == START);
    assign mult_a_o     = a_q;
    assign mult_b_o     = b_q;

endmodule

// File: tb/tb_mult_arb.sv
// Scoreboard bench for mult_arb with a behavioural multiplier model.
// Expected products and grant orders are derived from the arbitration rules.
module tb_mult_arb;

    localparam int N  = 3;
    localparam int AW = 24;
    localparam int BW = 16;
    localparam int PW = 40;
    localparam int K  = 4;

    typedef struct {
        int            idx;
        logic [PW-1:0] e;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_v;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic [N-1:0]      ack;
    logic [PW-1:0]     prod;
    logic              busy;
    logic              mstart;
    logic [AW-1:0]     ma;
    logic [BW-1:0]     mb;
    logic              mready;
    logic [PW-1:0]     mprod;

    logic [AW-1:0]     a_v [N];
    logic [BW-1:0]     b_v [N];
    int                issued [N];
    int                acked [N];
    logic [N-1:0]      drop = '0;

    exp_t              sb [$];
    int                log_q [$];
    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                raise_cyc = 0;
    int                start_cyc = 0;
    int                ack_cyc = 0;
    int                start_cnt = 0;
    int                start_dbl = 0;
    int                ack_cnt = 0;
    int                cfg_d = K;
    bit                cfg_stale = 0;
    int                ref_last = N - 1;

    mult_arb dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req_v),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .ack_o        (ack),
        .prod_o       (prod),
        .busy_o       (busy),
        .mult_start_o (mstart),
        .mult_a_o     (ma),
        .mult_b_o     (mb),
        .mult_ready_i (mready),
        .mult_prod_i  (mprod)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always_comb begin
        req_v = '0;
        for (int i = 0; i < N; i++) begin
            req_v[i] = (issued[i] > acked[i]) && !drop[i];
        end
    end

    assign req_a = {a_v[2], a_v[1], a_v[0]};
    assign req_b = {b_v[2], b_v[1], b_v[0]};

    function automatic logic [PW-1:0] full_prod(input logic [AW-1:0] a,
                                                input logic [BW-1:0] b);
        logic [PW-1:0] sa;
        logic [PW-1:0] sbv;
        sa  = {{(PW-AW){a[AW-1]}}, a};
        sbv = {{(PW-BW){b[BW-1]}}, b};
        return sa * sbv;
    endfunction

    function automatic int ref_pick(input logic [N-1:0] m, input int last);
`ifdef MULT_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (m[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic raise(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        exp_t x;
        a_v[i] = a;
        b_v[i] = b;
        x.idx  = i;
        x.e    = full_prod(a, b);
        sb.push_back(x);
        issued[i]++;
        raise_cyc = cyc;
    endtask

    task automatic unexpect(input int i);
        int k;
        k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].idx == i) k = j;
        if (k >= 0) sb.delete(k);
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int n;
        n = 0;
        tick();
        while ((req_v != '0 || busy) && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", tag, n);
        end
    endtask

    // Multiplier model, ack monitor and scoreboard, all at the falling edge.
    initial begin : mon
        int t;
        int cur_d;
        bit cur_stale;
        bit prev;
        int k;
        logic [AW-1:0] oa;
        logic [BW-1:0] ob;
        t = -1;
        cur_d = 1;
        cur_stale = 0;
        prev = 0;
        oa = '0;
        ob = '0;
        mready = 1'b1;
        mprod = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                t = -1;
                prev = 0;
                mready = 1'b1;
            end else begin
                if (mstart) begin
                    start_cnt++;
                    start_cyc = cyc;
                    if (prev) start_dbl++;
                    t = 0;
                    oa = ma;
                    ob = mb;
                    if (cfg_d != 0) begin
                        cur_d = cfg_d;
                        cur_stale = cfg_stale;
                    end else begin
                        cur_d = int'($urandom_range(1, 5));
                        cur_stale = ($urandom_range(0, 1) == 1);
                    end
                    if (cur_stale && cur_d < 2) cur_d = 2;
                end else if (t >= 0) begin
                    t++;
                end
                prev = mstart;
                if (t == 1) begin
                    mready = cur_stale;
                    mprod = ~full_prod(oa, ob);
                end else if (t >= 2 && t <= cur_d) begin
                    mready = 1'b0;
                end
                if (t == cur_d + 1) begin
                    mready = 1'b1;
                    mprod = full_prod(oa, ob);
                    t = -1;
                end
                if (ack != '0) begin
                    ack_cnt++;
                    ack_cyc = cyc;
                    checks++;
                    if ($countones(ack) != 1) begin
                        errors++;
                        $display("FAIL ack_onehot: got %b want one-hot", ack);
                    end
                    for (int i = 0; i < N; i++) begin
                        if (ack[i]) begin
                            log_q.push_back(i);
                            acked[i]++;
                            k = -1;
                            foreach (sb[j]) if (k < 0 && sb[j].idx == i) k = j;
                            checks++;
                            if (k < 0) begin
                                errors++;
                                $display("FAIL ack_unexpected: req %0d acked, want no ack", i);
                            end else begin
                                if (prod !== sb[k].e) begin
                                    errors++;
                                    $display("FAIL prod_req%0d: got %h want %h", i, prod, sb[k].e);
                                end
                                sb.delete(k);
                            end
                            checks++;
                            if ({ma, mb} !== {oa, ob}) begin
                                errors++;
                                $display("FAIL operand_hold: got %h/%h want %h/%h", ma, mb, oa, ob);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin : stim
        int exp_o [$];
        logic [N-1:0] m;
        int w;
        int left;
        int n0;
        int n;
        int snap;
        int snap2;
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;

        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
            issued[i] = 0;
            acked[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", longint'(ack), 0);
        chk("rst_prod", longint'(prod), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_start", longint'(mstart), 0);
        chk("rst_a", longint'(ma), 0);
        chk("rst_b", longint'(mb), 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) tick();
        chk("idle_busy", longint'(busy), 0);
        chk("idle_starts", longint'(start_cnt), 0);

        // Single request, nominal multiplier latency
        cfg_d = K;
        raise(0, 24'd1000, 16'hFFFD);
        ref_last = ref_pick(3'b001, ref_last);
        wait_idle(50, "t1");
        chk("t1_start_lat", longint'(start_cyc - raise_cyc), 1);
        chk("t1_ack_lat", longint'(ack_cyc - raise_cyc), K + 3);
        chk("t1_prod", longint'($signed(prod)), -3000);

        // All three at once, twice
        for (int r = 0; r < 2; r++) begin
            log_q.delete();
            exp_o.delete();
            m = 3'b111;
            for (int k = 0; k < N; k++) begin
                w = ref_pick(m, ref_last);
                exp_o.push_back(w);
                m[w] = 1'b0;
                ref_last = w;
            end
            for (int i = 0; i < N; i++) raise(i, AW'(i * 100), 16'd2);
            wait_idle(100, "t2");
            for (int k = 0; k < N; k++) begin
                chk($sformatf("t2_order_r%0d_%0d", r, k),
                    (log_q.size() > k) ? longint'(log_q[k]) : -1, longint'(exp_o[k]));
            end
        end

        // Requester 0 re-raised four times while 2 is held
        log_q.delete();
        exp_o.delete();
        m = 3'b101;
        left = 4;
        while (m != '0) begin
            w = ref_pick(m, ref_last);
            exp_o.push_back(w);
            ref_last = w;
            if (w == 0) begin
                left--;
                if (left == 0) m[0] = 1'b0;
            end else begin
                m[w] = 1'b0;
            end
        end
        raise(0, AW'($urandom), BW'($urandom));
        raise(2, AW'($urandom), BW'($urandom));
        n0 = 1;
        n = 0;
        while (log_q.size() < 5 && n < 300) begin
            tick();
            n++;
            if (issued[0] == acked[0] && n0 < 4) begin
                raise(0, AW'($urandom), BW'($urandom));
                n0++;
            end
        end
        wait_idle(100, "t3");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_order_%0d", k),
                (log_q.size() > k) ? longint'(log_q[k]) : -1, longint'(exp_o[k]));
        end

        // Stale ready during the blanking cycle
        cfg_d = 3;
        cfg_stale = 1;
        ra = AW'($urandom);
        rb = BW'($urandom);
        raise(1, ra, rb);
        wait_idle(50, "t4");
        chk("t4_lat", longint'(ack_cyc - raise_cyc), 6);
        chk("t4_prod", longint'(prod), longint'(full_prod(ra, rb)));
        cfg_stale = 0;

        // Ready high in the first WAIT cycle
        cfg_d = 1;
        raise(2, AW'($urandom), BW'($urandom));
        wait_idle(50, "tmin");
        chk("min_lat", longint'(ack_cyc - raise_cyc), 4);

        // Extreme negative operands
        cfg_d = K;
        raise(0, 24'h800000, 16'h8000);
        wait_idle(50, "t6");
        chk("t6_prod", longint'($signed(prod)), longint'(1) << 38);

        // Request withdrawn before it could be granted
        cfg_d = 5;
        raise(0, AW'($urandom), BW'($urandom));
        tick();
        tick();
        snap = acked[1];
        raise(1, AW'($urandom), BW'($urandom));
        tick();
        tick();
        issued[1]--;
        unexpect(1);
        wait_idle(60, "drop_pre");
        chk("drop_pre_noack", longint'(acked[1] - snap), 0);

        // Request withdrawn after grant still completes
        cfg_d = K;
        snap = acked[2];
        raise(2, AW'($urandom), BW'($urandom));
        tick();
        tick();
        drop[2] = 1'b1;
        wait_idle(60, "drop_post");
        chk("drop_post_ack", longint'(acked[2] - snap), 1);
        drop[2] = 1'b0;

        // Reset in the middle of WAIT
        cfg_d = 6;
        raise(0, AW'($urandom), BW'($urandom));
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", longint'(ack), 0);
        chk("mid_rst_prod", longint'(prod), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_start", longint'(mstart), 0);
        chk("mid_rst_a", longint'(ma), 0);
        chk("mid_rst_b", longint'(mb), 0);
        for (int i = 0; i < N; i++) issued[i] = acked[i];
        sb.delete();
        ref_last = N - 1;
        snap = ack_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_no_ack", longint'(ack_cnt - snap), 0);
        cfg_d = K;
        snap2 = start_cnt;
        raise(1, AW'($urandom), BW'($urandom));
        wait_idle(50, "rst_restart");
        chk("rst_restart_lat", longint'(start_cyc - raise_cyc), 1);
        chk("rst_restart_starts", longint'(start_cnt - snap2), 1);

        // Random traffic with random multiplier latency
        cfg_d = 0;
        repeat (300) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (issued[i] == acked[i] && $urandom_range(0, 3) == 0) begin
                    raise(i, AW'($urandom), BW'($urandom));
                end
            end
        end
        wait_idle(400, "rand");

        chk("sb_empty", longint'(sb.size()), 0);
        chk("start_double", longint'(start_dbl), 0);
        chk("start_vs_ack", longint'(start_cnt), longint'(ack_cnt + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
